// File: rtl/xsleenacore_rom_loader.sv
// ROM download loader: steers the HPS ioctl byte stream into per-region BRAM
// write strobes, paces the HPS with ioctl_wait and validates length/protocol.
module xsleenacore_rom_loader #(
  parameter logic [7:0]  ROM_INDEX   = 8'h00,
  parameter int          WR_GAP      = 2,
  parameter logic [20:0] TOTAL_BYTES = 21'h100800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [19:0] bram_addr,
  output logic [7:0]  bram_data,
  output logic        bram_wr,
  output logic [6:0]  bram_cs,
  output logic        cpu_hold,
  output logic        load_ok,
  output logic        load_err,
  output logic [15:0] checksum
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  state;
  logic        dl_prev;
  logic [20:0] byte_cnt;
  logic [3:0]  gap_cnt;

  logic        index_match;
  logic        dl_rise;
  logic        accept;
  logic        gap_strobe;
  logic        count_good;

  logic [6:0]  region_cs;
  logic [19:0] region_base;
  logic        region_hit;
  logic [19:0] region_offset;

  assign index_match = (ioctl_index == ROM_INDEX);
  assign dl_rise     = ioctl_download & ~dl_prev & index_match;
  assign accept      = (state == S_LOAD) & ioctl_wr & ioctl_download & index_match;
  assign gap_strobe  = (state == S_GAP) & ioctl_wr & ioctl_download & index_match;
  assign count_good  = (byte_cnt == TOTAL_BYTES);
  assign ioctl_wait  = accept | (state == S_GAP);

  // Bases are kept to 20 bits: the subtraction is modulo 2^20 anyway, so the
  // PROM base 0x100000 collapses to zero.
  always_comb begin
    region_cs   = 7'b0000000;
    region_base = 20'h00000;
    if (ioctl_addr < 25'h0020000) begin
      region_cs   = 7'b0000001;
      region_base = 20'h00000;
    end else if (ioctl_addr < 25'h0030000) begin
      region_cs   = 7'b0000010;
      region_base = 20'h20000;
    end else if (ioctl_addr < 25'h0038000) begin
      region_cs   = 7'b0000100;
      region_base = 20'h30000;
    end else if (ioctl_addr < 25'h0040000) begin
      region_cs   = 7'b0001000;
      region_base = 20'h38000;
    end else if (ioctl_addr < 25'h0080000) begin
      region_cs   = 7'b0010000;
      region_base = 20'h40000;
    end else if (ioctl_addr < 25'h0100000) begin
      region_cs   = 7'b0100000;
      region_base = 20'h80000;
    end else if (ioctl_addr < 25'h0100800) begin
      region_cs   = 7'b1000000;
      region_base = 20'h00000;
    end
  end

  assign region_hit    = |region_cs;
  assign region_offset = ioctl_addr[19:0] - region_base;

  // dl_prev resets high so a download still active across reset is never
  // mistaken for a fresh rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      dl_prev   <= 1'b1;
      byte_cnt  <= '0;
      gap_cnt   <= '0;
      bram_wr   <= 1'b0;
      bram_cs   <= '0;
      bram_addr <= '0;
      bram_data <= '0;
      cpu_hold  <= 1'b1;
      load_ok   <= 1'b0;
      load_err  <= 1'b0;
      checksum  <= '0;
    end else begin
      dl_prev <= ioctl_download;
      bram_wr <= accept & region_hit;
      bram_cs <= (accept & region_hit) ? region_cs : 7'b0000000;
      if (accept & region_hit) begin
        bram_addr <= region_offset;
        bram_data <= ioctl_dout;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (dl_rise) begin
            state    <= S_LOAD;
            checksum <= '0;
            byte_cnt <= '0;
            load_ok  <= 1'b0;
            load_err <= 1'b0;
            cpu_hold <= 1'b1;
          end
        end
        S_LOAD: begin
          if (!ioctl_download) begin
            state <= S_CHECK;
          end else if (accept) begin
            checksum <= checksum + {8'h00, ioctl_dout};
            byte_cnt <= (&byte_cnt) ? byte_cnt : byte_cnt + 21'd1;
            if (!region_hit) begin
              load_err <= 1'b1;
            end
            gap_cnt <= 4'(WR_GAP - 1);
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (!ioctl_download) begin
            state <= S_CHECK;
          end else begin
            if (gap_strobe) begin
              load_err <= 1'b1;
            end
            if (gap_cnt == 4'd0) begin
              state <= S_LOAD;
            end else begin
              gap_cnt <= gap_cnt - 4'd1;
            end
          end
        end
        S_CHECK: begin
          load_ok  <= count_good & ~load_err;
          cpu_hold <= ~(count_good & ~load_err);
          if (!count_good) begin
            load_err <= 1'b1;
          end
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xsleenacore_rom_loader.sv
// Directed bench for xsleenacore_rom_loader: region decode table plus
// hand-written load, gap-violation, wrong-index and reset-abort sequences.
module tb_xsleenacore_rom_loader;

  localparam logic [20:0] TOTAL = 21'd32;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [19:0] bram_addr;
  logic [7:0]  bram_data;
  logic        bram_wr;
  logic [6:0]  bram_cs;
  logic        cpu_hold;
  logic        load_ok;
  logic        load_err;
  logic [15:0] checksum;

  int checks = 0;
  int errors = 0;

  logic        cap_wr;
  logic [6:0]  cap_cs;
  logic [19:0] cap_addr;
  logic [7:0]  cap_data;
  logic        cap_wait_pre;
  logic [15:0] sum16;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
    logic        exp_wr;
    logic [6:0]  exp_cs;
    logic [19:0] exp_addr;
    logic [7:0]  exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  xsleenacore_rom_loader #(
    .ROM_INDEX   (8'h00),
    .WR_GAP      (2),
    .TOTAL_BYTES (TOTAL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .bram_addr      (bram_addr),
    .bram_data      (bram_data),
    .bram_wr        (bram_wr),
    .bram_cs        (bram_cs),
    .cpu_hold       (cpu_hold),
    .load_ok        (load_ok),
    .load_err       (load_err),
    .checksum       (checksum)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge; outputs are captured 1 ns after the accepting edge.
  task automatic apply_stimulus(input logic [24:0] a, input logic [7:0] d);
    int n;
    n = 0;
    while (ioctl_wait && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check_output("wait_release_timeout", 32'(ioctl_wait), 32'd0);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    #1 cap_wait_pre = ioctl_wait;
    @(posedge clk);
    #1;
    cap_wr   = bram_wr;
    cap_cs   = bram_cs;
    cap_addr = bram_addr;
    cap_data = bram_data;
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic stream(input logic [24:0] base, input int count, input logic [7:0] value);
    for (int i = 0; i < count; i++) begin
      apply_stimulus(base + 25'(i), value);
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    @(negedge clk);
  endtask

  task automatic end_dl(input string tag, input logic exp_ok, input logic exp_err, input logic exp_hold);
    ioctl_download = 1'b0;
    @(posedge clk);
    #1;
    check_output({tag, "_hold_in_check"}, 32'(cpu_hold), 32'd1);
    @(posedge clk);
    #1;
    check_output({tag, "_load_ok"}, 32'(load_ok), 32'(exp_ok));
    check_output({tag, "_load_err"}, 32'(load_err), 32'(exp_err));
    check_output({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(exp_hold));
    check_output({tag, "_wait_done"}, 32'(ioctl_wait), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{25'h0038123, 8'hA5, 1'b1, 7'b0001000, 20'h00123, 8'hA5, 1'b0};
    vecs[1] = '{25'h0000010, 8'h11, 1'b1, 7'b0000001, 20'h00010, 8'h11, 1'b0};
    vecs[2] = '{25'h001FFFF, 8'h22, 1'b1, 7'b0000001, 20'h1FFFF, 8'h22, 1'b0};
    vecs[3] = '{25'h0020000, 8'h33, 1'b1, 7'b0000010, 20'h00000, 8'h33, 1'b0};
    vecs[4] = '{25'h0037FFF, 8'h44, 1'b1, 7'b0000100, 20'h07FFF, 8'h44, 1'b0};
    vecs[5] = '{25'h003FFFF, 8'h55, 1'b1, 7'b0001000, 20'h07FFF, 8'h55, 1'b0};
    vecs[6] = '{25'h0040005, 8'h66, 1'b1, 7'b0010000, 20'h00005, 8'h66, 1'b0};
    vecs[7] = '{25'h00FFFFF, 8'h77, 1'b1, 7'b0100000, 20'h7FFFF, 8'h77, 1'b0};
    vecs[8] = '{25'h01007FF, 8'h88, 1'b1, 7'b1000000, 20'h007FF, 8'h88, 1'b0};
    vecs[9] = '{25'h0100800, 8'h99, 1'b0, 7'b0000000, 20'h007FF, 8'h88, 1'b1};

    ioctl_download = 1'b0;
    ioctl_index    = 8'h00;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    reset          = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_output("rst_bram_wr", 32'(bram_wr), 32'd0);
    check_output("rst_bram_cs", 32'(bram_cs), 32'd0);
    check_output("rst_bram_addr", 32'(bram_addr), 32'd0);
    check_output("rst_bram_data", 32'(bram_data), 32'd0);
    check_output("rst_wait", 32'(ioctl_wait), 32'd0);
    check_output("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check_output("rst_flags", {30'd0, load_ok, load_err}, 32'd0);
    check_output("rst_checksum", 32'(checksum), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Region decode table inside a single download.
    $display("[TB] region decode table");
    sum16 = 16'h0000;
    start_dl(8'h00);
    check_output("load_entry_wait", 32'(ioctl_wait), 32'd0);
    check_output("load_entry_hold", 32'(cpu_hold), 32'd1);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].addr, vecs[i].data);
      sum16 = sum16 + {8'h00, vecs[i].data};
      check_output($sformatf("v%0d_bram_wr", i), 32'(cap_wr), 32'(vecs[i].exp_wr));
      check_output($sformatf("v%0d_bram_cs", i), 32'(cap_cs), 32'(vecs[i].exp_cs));
      check_output($sformatf("v%0d_bram_addr", i), 32'(cap_addr), 32'(vecs[i].exp_addr));
      check_output($sformatf("v%0d_bram_data", i), 32'(cap_data), 32'(vecs[i].exp_data));
      check_output($sformatf("v%0d_wait_accept", i), 32'(cap_wait_pre), 32'd1);
      check_output($sformatf("v%0d_wait_gap1", i), 32'(ioctl_wait), 32'd1);
      @(negedge clk);
      check_output($sformatf("v%0d_wait_gap2", i), 32'(ioctl_wait), 32'd1);
      check_output($sformatf("v%0d_wr_idle", i), 32'(bram_wr), 32'd0);
      check_output($sformatf("v%0d_cs_idle", i), 32'(bram_cs), 32'd0);
      check_output($sformatf("v%0d_addr_hold", i), 32'(bram_addr), 32'(vecs[i].exp_addr));
      @(negedge clk);
      check_output($sformatf("v%0d_wait_release", i), 32'(ioctl_wait), 32'd0);
      check_output($sformatf("v%0d_checksum", i), 32'(checksum), 32'(sum16));
      check_output($sformatf("v%0d_load_err", i), 32'(load_err), 32'(vecs[i].exp_err));
    end
    end_dl("table", 1'b0, 1'b1, 1'b1);

    // Complete, correct load.
    $display("[TB] good load");
    start_dl(8'h00);
    check_output("good_entry_err", 32'(load_err), 32'd0);
    check_output("good_entry_sum", 32'(checksum), 32'd0);
    stream(25'h0, 32, 8'h01);
    end_dl("good", 1'b1, 1'b0, 1'b0);
    check_output("good_checksum", 32'(checksum), 32'h0020);

    // Download with a foreign index is ignored.
    $display("[TB] wrong index");
    start_dl(8'h01);
    ioctl_addr = 25'h0;
    ioctl_dout = 8'h5A;
    ioctl_wr   = 1'b1;
    #1;
    check_output("idx_wait", 32'(ioctl_wait), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_output("idx_bram_wr", 32'(bram_wr), 32'd0);
    check_output("idx_load_ok", 32'(load_ok), 32'd1);
    check_output("idx_cpu_hold", 32'(cpu_hold), 32'd0);
    check_output("idx_checksum", 32'(checksum), 32'h0020);
    @(negedge clk);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    @(negedge clk);

    // Strobe during the gap: dropped, flags an error.
    $display("[TB] gap violation");
    start_dl(8'h00);
    check_output("gapv_entry_ok", 32'(load_ok), 32'd0);
    check_output("gapv_entry_hold", 32'(cpu_hold), 32'd1);
    apply_stimulus(25'h0, 8'h01);
    check_output("gapv_first_wr", 32'(cap_wr), 32'd1);
    ioctl_wr = 1'b1;
    @(posedge clk);
    #1;
    check_output("gapv_dropped_wr", 32'(bram_wr), 32'd0);
    check_output("gapv_err_set", 32'(load_err), 32'd1);
    @(negedge clk);
    ioctl_wr = 1'b0;
    stream(25'h1, 31, 8'h01);
    check_output("gapv_checksum", 32'(checksum), 32'h0020);
    end_dl("gapv", 1'b0, 1'b1, 1'b1);

    // Strobe coincident with the download rising edge is ignored.
    $display("[TB] strobe on download rise");
    ioctl_addr     = 25'h0;
    ioctl_dout     = 8'h5A;
    ioctl_index    = 8'h00;
    ioctl_wr       = 1'b1;
    ioctl_download = 1'b1;
    @(posedge clk);
    #1;
    check_output("rise_bram_wr", 32'(bram_wr), 32'd0);
    @(negedge clk);
    ioctl_wr = 1'b0;
    @(posedge clk);
    #1;
    check_output("rise_bram_wr2", 32'(bram_wr), 32'd0);
    check_output("rise_checksum", 32'(checksum), 32'd0);
    @(negedge clk);

    // Reset in the middle of a load, then a full restart.
    $display("[TB] reset mid-load");
    stream(25'h0, 10, 8'h01);
    check_output("abort_pre_wr", 32'(bram_wr), 32'd1);
    reset = 1'b1;
    #1;
    check_output("abort_bram_wr", 32'(bram_wr), 32'd0);
    check_output("abort_bram_cs", 32'(bram_cs), 32'd0);
    check_output("abort_bram_addr", 32'(bram_addr), 32'd0);
    check_output("abort_bram_data", 32'(bram_data), 32'd0);
    check_output("abort_checksum", 32'(checksum), 32'd0);
    check_output("abort_cpu_hold", 32'(cpu_hold), 32'd1);
    check_output("abort_wait", 32'(ioctl_wait), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    apply_stimulus(25'h5, 8'h01);
    check_output("abort_no_resume_wr", 32'(cap_wr), 32'd0);
    check_output("abort_no_resume_sum", 32'(checksum), 32'd0);
    ioctl_download = 1'b0;
    @(negedge clk);
    start_dl(8'h00);
    stream(25'h0, 32, 8'h01);
    end_dl("restart", 1'b1, 1'b0, 1'b0);
    check_output("restart_checksum", 32'(checksum), 32'h0020);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
